// File: rtl/affine_fir_pipe.sv
// affine_fir_pipe
// Streaming N-tap fractional-sample interpolation filter with a run-time
// loadable PHASES x NTAPS coefficient bank and a two-stage pipeline.
//
// Ports:
//   clk        clock, all state updates on the rising edge
//   rst        synchronous active-high reset (clears bank, window, pipeline)
//   cfg_we     coefficient write strobe
//   cfg_phase  phase row to write
//   cfg_tap    tap column to write
//   cfg_coef   signed coefficient value
//   in_valid   input sample valid
//   in_ready   block can accept a sample
//   in_start   first sample of a new row (qualified by in_valid)
//   in_sample  signed input sample
//   in_phase   phase for the output this sample completes
//   out_valid  out_data valid
//   out_ready  downstream accepts
//   out_data   signed, rounded, shifted and saturated filter result
module affine_fir_pipe #(
  parameter int IN_SIZE   = 8,
  parameter int COEF_SIZE = 8,
  parameter int NTAPS     = 6,
  parameter int PHASES    = 16,
  parameter int SHIFT     = 6,
  parameter int OUT_SIZE  = 16
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              cfg_we,
  input  logic [$clog2(PHASES)-1:0]         cfg_phase,
  input  logic [$clog2(NTAPS)-1:0]          cfg_tap,
  input  logic signed [COEF_SIZE-1:0]       cfg_coef,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic                              in_start,
  input  logic signed [IN_SIZE-1:0]         in_sample,
  input  logic [$clog2(PHASES)-1:0]         in_phase,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic signed [OUT_SIZE-1:0]        out_data
);

  localparam int PW    = $clog2(PHASES);
  localparam int TW    = $clog2(NTAPS);
  localparam int PRODW = IN_SIZE + COEF_SIZE;
  localparam int ACCW  = PRODW + $clog2(NTAPS);
  localparam int FW    = $clog2(NTAPS + 1);
  // Saturation compare width: wide enough for both the shifted sum and the
  // output range, plus a sign bit so the limits are representable.
  localparam int SATW  = ((ACCW > OUT_SIZE) ? ACCW : OUT_SIZE) + 1;

  localparam logic [FW-1:0]          FULL    = FW'(NTAPS);
  localparam logic [PW:0]            PH_LIM  = (PW+1)'(PHASES);
  localparam logic [TW:0]            TAP_LIM = (TW+1)'(NTAPS);
  localparam logic signed [ACCW-1:0] RND     = ACCW'((1 << SHIFT) >> 1);
  localparam logic signed [SATW-1:0] MAXV    = {{(SATW-OUT_SIZE+1){1'b0}}, {(OUT_SIZE-1){1'b1}}};
  localparam logic signed [SATW-1:0] MINV    = {{(SATW-OUT_SIZE+1){1'b1}}, {(OUT_SIZE-1){1'b0}}};

  logic signed [COEF_SIZE-1:0] coef_reg [PHASES][NTAPS];
  logic signed [IN_SIZE-1:0]   win_reg  [NTAPS];
  logic signed [IN_SIZE-1:0]   win_next [NTAPS];
  logic signed [COEF_SIZE-1:0] coef_sel [NTAPS];
  logic signed [PRODW-1:0]     prod_reg [NTAPS];
  logic signed [PRODW-1:0]     prod_next[NTAPS];
  logic [FW-1:0]               fill_reg, fill_next;
  logic                        s1_valid_reg;
  logic                        out_valid_reg;
  logic signed [OUT_SIZE-1:0]  out_data_reg;

  logic                        stall, accept, phase_ok, cfg_ok;
  logic signed [ACCW-1:0]      acc, shifted;
  logic signed [SATW-1:0]      shifted_ext;
  logic signed [OUT_SIZE-1:0]  sat_val;

  assign stall    = out_valid_reg && !out_ready;
  assign in_ready = !stall && !rst;
  assign accept   = in_valid && in_ready;
  assign phase_ok = ({1'b0, in_phase} < PH_LIM);
  assign cfg_ok   = ({1'b0, cfg_phase} < PH_LIM) && ({1'b0, cfg_tap} < TAP_LIM);

  assign out_valid = out_valid_reg;
  assign out_data  = out_data_reg;

  // Coefficient bank; out-of-range write addresses are dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int p = 0; p < PHASES; p++)
        for (int t = 0; t < NTAPS; t++)
          coef_reg[p][t] <= '0;
    end else if (cfg_we && cfg_ok) begin
      coef_reg[cfg_phase][cfg_tap] <= cfg_coef;
    end
  end

  // Post-shift window and the products it feeds. A start sample zeroes the
  // older taps so nothing from the previous row can leak into the new one.
  genvar gi;
  generate
    for (gi = 0; gi < NTAPS; gi++) begin : g_tap
      if (gi == NTAPS - 1) begin : g_newest
        assign win_next[gi] = in_sample;
      end else begin : g_older
        assign win_next[gi] = in_start ? '0 : win_reg[gi+1];
      end
      assign coef_sel[gi]  = phase_ok ? coef_reg[in_phase][gi] : '0;
      assign prod_next[gi] = PRODW'(coef_sel[gi]) * PRODW'(win_next[gi]);
    end
  endgenerate

  always_comb begin
    fill_next = fill_reg;
    if (in_start)
      fill_next = FW'(1);
    else if (fill_reg != FULL)
      fill_next = fill_reg + FW'(1);
  end

  // Stage 1: window, fill count and products. accept already implies no
  // stall; a non-stalled edge without an accept inserts a bubble.
  always_ff @(posedge clk) begin
    if (rst) begin
      fill_reg     <= '0;
      s1_valid_reg <= 1'b0;
      for (int k = 0; k < NTAPS; k++) begin
        win_reg[k]  <= '0;
        prod_reg[k] <= '0;
      end
    end else if (accept) begin
      fill_reg     <= fill_next;
      s1_valid_reg <= (fill_next == FULL);
      for (int k = 0; k < NTAPS; k++) begin
        win_reg[k]  <= win_next[k];
        prod_reg[k] <= prod_next[k];
      end
    end else if (!stall) begin
      s1_valid_reg <= 1'b0;
    end
  end

  // Stage 2 datapath: rounded sum, arithmetic shift, saturation.
  always_comb begin
    acc = RND;
    for (int k = 0; k < NTAPS; k++)
      acc = acc + ACCW'(prod_reg[k]);
  end

  assign shifted     = acc >>> SHIFT;
  assign shifted_ext = SATW'(shifted);

  always_comb begin
    sat_val = shifted_ext[OUT_SIZE-1:0];
    if (shifted_ext > MAXV)
      sat_val = MAXV[OUT_SIZE-1:0];
    else if (shifted_ext < MINV)
      sat_val = MINV[OUT_SIZE-1:0];
  end

  // Stage 2 register; out_data only moves when a new result lands so it
  // stays stable through stalls and bubbles.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_reg <= 1'b0;
      out_data_reg  <= '0;
    end else if (!stall) begin
      out_valid_reg <= s1_valid_reg;
      if (s1_valid_reg)
        out_data_reg <= sat_val;
    end
  end

endmodule

// File: doc/affine_fir_pipe.md
Name: affine_fir_pipe

Overview:
Streaming, parametrised N-tap fractional-sample interpolation filter for the affine interpolation path. It is the sequential successor of the fixed per-tap MCM blocks. It keeps a sliding window of NTAPS input samples and holds a run-time-loadable coefficient bank of PHASES x NTAPS entries. Each window position produces one rounded, shifted and saturated output for the fractional phase supplied with the sample that completes the window. The pipeline is two stages deep, with a valid/ready handshake on both sides.

Parameters:
IN_SIZE, 8, signed input sample width
COEF_SIZE, 8, signed coefficient width
NTAPS, 6, filter taps (2..8)
PHASES, 16, fractional positions (1/16 precision)
SHIFT, 6, normalisation right shift (0..15)
OUT_SIZE, 16, signed output width (saturated)

Ports:
clk  in  1  clock; all state updates on the rising edge
rst  in  1  synchronous reset, active-high
cfg_we  in  1  coefficient write strobe
cfg_phase  in  $clog2(PHASES)  phase row to write
cfg_tap  in  $clog2(NTAPS)  tap column to write
cfg_coef  in  COEF_SIZE  signed coefficient value
in_valid  in  1  input sample valid
in_ready  out  1  block can accept a sample
in_start  in  1  first sample of a new row (qualified by in_valid)
in_sample  in  IN_SIZE  signed sample
in_phase  in  $clog2(PHASES)  phase for the output this sample completes
out_valid  out  1  out_data valid
out_ready  in  1  downstream accepts
out_data  out  OUT_SIZE  signed filtered result

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high. While rst=1, every register clears on each edge:
  - coefficient bank = 0, window = 0, fill count = 0;
  - stage-1 valid = 0, out_valid = 0, out_data = 0.
  - in_ready = 0 during reset and 1 on the first cycle after reset.
  - Reset mid-operation drops all in-flight data and erases the coefficients; they must be reloaded.
- Accept: a sample is accepted when in_valid && in_ready.
- Stall: stall = out_valid && !out_ready. in_ready = !stall && !rst. During a stall, stage 1, stage 2 and the window hold and out_data stays stable.
- Window: win[0] is the oldest sample and win[NTAPS-1] the newest. On accept, the window shifts: new sample into win[NTAPS-1], win[k] <= win[k+1].
  - If in_start=1: the window is zeroed, the sample is loaded into win[NTAPS-1], and fill = 1.
  - Otherwise fill = min(fill+1, NTAPS).
  - in_start without in_valid is ignored.
- Stage 1 (edge of accept):
  - Fires only if fill after the accept equals NTAPS.
  - Registers NTAPS products p[k] = coef[in_phase][k] * win'[k], where win' is the post-shift window. Each product is IN_SIZE+COEF_SIZE bits, signed.
  - Sets s1_valid. If the accept does not complete a full window, s1_valid = 0 (bubble).
- Stage 2 (next non-stalled edge):
  - acc = sum of p[k] + (SHIFT>0 ? 1<<(SHIFT-1) : 0), sized IN_SIZE+COEF_SIZE+$clog2(NTAPS) bits.
  - r = acc >>> SHIFT (arithmetic shift).
  - out_data = r saturated to [-2^(OUT_SIZE-1), 2^(OUT_SIZE-1)-1].
  - out_valid <= s1_valid.
- Latency: 2 cycles from the accept edge to out_valid when there is no stall. Throughput is 1 output per cycle in steady state, and outputs leave in order.
- Output hold: out_valid drops after an out_ready handshake if no new result follows.
- Coefficient writes:
  - On any edge with cfg_we=1 (no rst), coef[cfg_phase][cfg_tap] <= cfg_coef.
  - A sample accepted in the same cycle as a write uses the old value.
  - Writes are legal during a stall.
- Out-of-range indices: writes with cfg_phase >= PHASES or cfg_tap >= NTAPS are ignored. An in_phase >= PHASES selects all-zero coefficients.

Test Plan:
- Identity: load phase 0 row {0,0,64,0,0,0}. Stream 1..8 with in_start on the first sample, phase 0, out_ready=1 -> exactly 3 outputs: 3, 4, 5. The first output appears 2 cycles after sample 6 is accepted.
- Half-pel: load phase 8 row {3,-11,40,40,-11,3}. Send a constant input of 100 -> 100 every cycle after fill. Input 0,0,0,64,0,0 -> (40*64+32)>>6 = 40.
- Rounding: row {1,0,0,0,0,0}, with win[0] = 32 / 31 / -32 / -33 -> outputs 1 / 0 / 0 / -1.
- Saturation: OUT_SIZE=10, all coefficients 127.
  - All inputs 127 -> 511 (raw 1512).
  - All inputs -128 -> -512 (raw -1524).
- Backpressure: during streaming, hold out_ready=0 for 5 cycles -> in_ready=0 while out_valid=1, out_data unchanged. After release there is no loss or duplication, and the sequence equals the no-stall golden model.
- Restart and reset:
  - Assert in_start mid-row -> no output until NTAPS new samples arrive, and no old samples appear in the window.
  - Assert rst mid-stream -> next edge gives out_valid=0 and out_data=0. After reload, the first output matches the golden model.
